char_buf_ctrl: RTL and testbench
================================

# char_buf_ctrl

Command-driven controller that owns the write port of the 16x16 character buffer feeding the text-overlay path: the buffer that maps a `char_xy` cell to a `char_code`, which is then looked up in the font ROM and drawn over the VGA stream. It runs clear, fill and string-write commands, and streams character codes into consecutive cells. Buffer writes happen only while `vblank` is high, so the overlay never tears mid-frame. It sits between game-state logic (the command source) and the character buffer RAM.

## Interface
Parameters:
- `BLANK_CODE`, 7'h20: code written by CLEAR.

Ports (clock and reset first):
- `clk`  in  1  system/pixel clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `vblank`  in  1  write window; high during vertical blanking.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  00 NOP, 01 CLEAR, 10 FILL, 11 WRITE.
- `cmd_xy`  in  8  start cell {row[7:4], col[3:0]}; used by WRITE only.
- `cmd_code`  in  7  fill code; used by FILL only.
- `char_valid`  in  1  stream beat valid (WRITE).
- `char_ready`  out  1  stream beat accepted when `char_valid && char_ready`.
- `char_code_in`  in  7  character code of the beat.
- `char_last`  in  1  final beat of the string.
- `wr_en`  out  1  buffer write strobe.
- `wr_addr`  out  8  buffer address {row, col}.
- `wr_data`  out  7  buffer write data.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, FILLING (used by CLEAR and FILL), WRITING, DONE.
- IDLE: `cmd_ready`=1. On handshake, latch op, code and xy:
  - NOP goes to DONE.
  - CLEAR goes to FILLING with data=`BLANK_CODE`, addr=0.
  - FILL goes to FILLING with data=`cmd_code`, addr=0.
  - WRITE goes to WRITING with addr=`cmd_xy`.
- FILLING: each cycle with `vblank`=1, write data at addr and increment addr. After the write to 255, go to DONE. With `vblank`=0, hold addr and do not write.
- WRITING: `char_ready` = `vblank`. Each accepted beat writes `char_code_in` at addr and increments addr. An accepted beat with `char_last`=1 goes to DONE. Beats are never accepted outside WRITING.
- Address arithmetic is 8-bit modulo 256. Col 15 rolls to col 0 of the next row; cell 255 wraps to cell 0 (WRITE only; FILLING ends at 255).
- DONE: lasts one cycle with `done`=1, then IDLE.
- `vblank` falling mid-command pauses the command; it resumes at the next `vblank` rise with no lost or duplicated cells.
- A command presented while `busy` is held off (`cmd_ready`=0). It is not dropped; the source keeps `cmd_valid` asserted.
- Async reset mid-command aborts it: no `done`; the buffer keeps whatever was already written.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=0, then 1 from the first clock after release. `char_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- `wr_en`, `wr_addr` and `wr_data` are registered. A write appears one cycle after the cycle that issued it (the FILLING step or the stream handshake).
- CLEAR/FILL: 256 vblank-high cycles. `done` asserts 2 cycles after the last issuing cycle (1 cycle to DONE, `done` registered in DONE). The last `wr_en` and `done` are therefore 1 cycle apart.
- WRITE of N beats with continuous `vblank`/`char_valid`: N cycles of writes, then `done`. Back-to-back commands need at least one IDLE cycle between them.
- `char_ready` and `cmd_ready` are combinational from state and `vblank`. No combinational path from `char_valid` to `char_ready`.

## Test plan
- Reset, then CLEAR with `vblank` held 1: 256 writes, addr 0..255, data 7'h20; `done` 1 cycle after the last write; `busy` low afterwards.
- FILL with `cmd_code`=7'h41 and `vblank` toggling 100 cycles on / 100 off: exactly 256 writes, each address once, no writes while `vblank`=0.
- WRITE with `cmd_xy`=8'h3E and beats "ABC" (7'h41, 7'h42, 7'h43, last on C): writes at 0x3E, 0x3F, 0x40; `done` pulses once.
- WRITE with `cmd_xy`=8'hFF and 2 beats: writes at 0xFF, then 0x00 (wrap).
- `cmd_valid` asserted with CLEAR during an active WRITE: `cmd_ready`=0 until IDLE, then accepted; the WRITE completes intact.
- `rst` asserted mid-FILL at addr 0x80: all outputs return to reset values asynchronously; no `done`; the next CLEAR restarts from addr 0.

Source files
------------

// File: rtl/char_buf_ctrl_if.sv
// Command, character-stream and buffer-write bundle for char_buf_ctrl.
//   cmd_*  : command request from game-state logic (valid/ready handshake)
//   char_* : character stream for WRITE (valid/ready handshake, last marks end)
//   wr_*   : write port of the 16x16 character buffer RAM
// master = command/stream source side, slave = controller side.
interface char_buf_ctrl_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CODE_W = 7;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_xy;
  logic [CODE_W-1:0] cmd_code;

  logic              char_valid;
  logic              char_ready;
  logic [CODE_W-1:0] char_code_in;
  logic              char_last;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CODE_W-1:0] wr_data;

  modport master (
    output cmd_valid, cmd_op, cmd_xy, cmd_code,
    output char_valid, char_code_in, char_last,
    input  cmd_ready, char_ready,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_xy, cmd_code,
    input  char_valid, char_code_in, char_last,
    output cmd_ready, char_ready,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/char_buf_ctrl.sv
// Character-buffer write controller: runs CLEAR / FILL / WRITE commands against
// the 16x16 overlay character buffer, writing only while vblank is high.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-low reset
//   vblank : write window (high during vertical blanking)
//   bus    : command, character stream and buffer write port (slave side)
//   busy   : high whenever the controller is not idle
//   done   : one-cycle pulse when a command completes
module char_buf_ctrl #(
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vblank,
  char_buf_ctrl_if.slave bus,
  output logic           busy,
  output logic           done
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CODE_W = 7;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILLING,
    ST_WRITING,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic              ready_q;
  logic              issue_c;
  logic [CODE_W-1:0] wdata_c;

  // Handshake readies depend only on state and vblank; ready_q keeps cmd_ready
  // low until the first clock after reset release.
  assign bus.cmd_ready  = ready_q && (state_q == ST_IDLE);
  assign bus.char_ready = vblank && (state_q == ST_WRITING);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= 1'b1;
    end
  end

  // Next-state, address stepping and write issue.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    issue_c = 1'b0;
    wdata_c = data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          case (bus.cmd_op)
            OP_NOP: begin
              state_d = ST_DONE;
            end
            OP_CLEAR: begin
              state_d = ST_FILLING;
              data_d  = BLANK_CODE;
              addr_d  = '0;
            end
            OP_FILL: begin
              state_d = ST_FILLING;
              data_d  = bus.cmd_code;
              addr_d  = '0;
            end
            OP_WRITE: begin
              state_d = ST_WRITING;
              addr_d  = bus.cmd_xy;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_FILLING: begin
        // Whole buffer sweep; stops after cell 255 instead of wrapping.
        if (vblank) begin
          issue_c = 1'b1;
          addr_d  = ADDR_W'(addr_q + 8'd1);
          if (addr_q == '1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITING: begin
        // Address wraps modulo 256 so a string may run past cell 255.
        if (bus.char_valid && bus.char_ready) begin
          issue_c = 1'b1;
          wdata_c = bus.char_code_in;
          addr_d  = ADDR_W'(addr_q + 8'd1);
          if (bus.char_last) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Registered buffer write port and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      bus.wr_en <= issue_c;
      if (issue_c) begin
        bus.wr_addr <= addr_q;
        bus.wr_data <= wdata_c;
      end
      busy <= (state_d != ST_IDLE);
      done <= (state_q == ST_DONE);
    end
  end

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Randomized bench for char_buf_ctrl with a command-level reference model:
// each accepted command expands into its list of expected buffer writes.
module tb_char_buf_ctrl;

  localparam logic [6:0] BLANK = 7'h20;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vblank = 1'b0;
  logic busy;
  logic done;

  char_buf_ctrl_if bus_if ();

  char_buf_ctrl #(.BLANK_CODE(BLANK)) dut (
    .clk    (clk),
    .rst    (rst),
    .vblank (vblank),
    .bus    (bus_if),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] xy;
    logic [6:0] code;
    int         len;
    int         base;
  } cmd_t;

  cmd_t        pend[$];
  logic [6:0]  pool[$];
  logic [14:0] exp_q[$];   // {addr, data} in expected write order

  bit outstanding = 0;
  bit in_write    = 0;
  bit cur_has_wr  = 0;
  bit saw_80      = 0;
  int beat_idx = 0, beat_len = 0, beat_base = 0;
  int cyc = 0, last_wr_cyc = 0;
  int vb_mode = 0, cv_mode = 0, tog_cnt = 0;

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] xy,
                          input logic [6:0] code, input int len);
    cmd_t c;
    c.op = op; c.xy = xy; c.code = code; c.len = len;
    c.base = pool.size() - len;
    pend.push_back(c);
  endtask

  // Expand an accepted command into the writes it must produce.
  task automatic accept_cmd(input cmd_t c);
    outstanding = 1;
    cur_has_wr  = (c.op != OP_NOP);
    case (c.op)
      OP_CLEAR: for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), BLANK});
      OP_FILL:  for (int a = 0; a < 256; a++) exp_q.push_back({8'(a), c.code});
      OP_WRITE: begin
        for (int i = 0; i < c.len; i++)
          exp_q.push_back({8'((int'(c.xy) + i) % 256), pool[c.base + i]});
        in_write  = 1;
        beat_idx  = 0;
        beat_len  = c.len;
        beat_base = c.base;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    logic [14:0] e;
    cmd_t c;
    @(negedge clk);
    cyc++;
    if (bus_if.wr_en) begin
      check_eq("wr_in_vblank", 32'(vblank), 1);
      if (exp_q.size() == 0) check_eq("extra_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(bus_if.wr_addr), 32'(e[14:7]));
        check_eq("wr_data", 32'(bus_if.wr_data), 32'(e[6:0]));
      end
      last_wr_cyc = cyc;
      if (bus_if.wr_addr == 8'h80) saw_80 = 1;
    end
    if (done) begin
      if (!outstanding) check_eq("spurious_done", 1, 0);
      else begin
        check_eq("done_writes_left", 32'(exp_q.size()), 0);
        if (cur_has_wr) check_eq("done_gap", 32'(cyc - last_wr_cyc), 1);
        outstanding = 0;
      end
    end
    check_eq("busy", 32'(busy), 32'(outstanding));

    tog_cnt++;
    case (vb_mode)
      0:       vblank = 1'b1;
      1:       vblank = (tog_cnt % 200) < 100;
      default: vblank = ($urandom % 4) != 0;
    endcase
    if (pend.size() > 0) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = pend[0].op;
      bus_if.cmd_xy    = pend[0].xy;
      bus_if.cmd_code  = pend[0].code;
    end else begin
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 2'($urandom);
      bus_if.cmd_xy    = 8'($urandom);
      bus_if.cmd_code  = 7'($urandom);
    end
    if (in_write) begin
      bus_if.char_valid   = (cv_mode == 0) ? 1'b1 : 1'($urandom);
      bus_if.char_code_in = pool[beat_base + beat_idx];
      bus_if.char_last    = (beat_idx == beat_len - 1);
    end else begin
      bus_if.char_valid   = 1'($urandom);
      bus_if.char_code_in = 7'($urandom);
      bus_if.char_last    = 1'($urandom);
    end

    #1;
    check_eq("char_ready", 32'(bus_if.char_ready), 32'(in_write && vblank));
    check_eq("cmd_ready", 32'(bus_if.cmd_ready), 32'(!outstanding));
    if (in_write && bus_if.char_valid && bus_if.char_ready) begin
      beat_idx++;
      if (beat_idx == beat_len) in_write = 0;
    end
    if (bus_if.cmd_valid && bus_if.cmd_ready) begin
      c = pend.pop_front();
      accept_cmd(c);
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    while ((pend.size() > 0 || outstanding) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("phase_timeout", 32'(pend.size() > 0 || outstanding), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"},  32'(bus_if.cmd_ready), 0);
    check_eq({tag, "_char_ready"}, 32'(bus_if.char_ready), 0);
    check_eq({tag, "_wr_en"},      32'(bus_if.wr_en), 0);
    check_eq({tag, "_wr_addr"},    32'(bus_if.wr_addr), 0);
    check_eq({tag, "_wr_data"},    32'(bus_if.wr_data), 0);
    check_eq({tag, "_busy"},       32'(busy), 0);
    check_eq({tag, "_done"},       32'(done), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("cmd_ready_before_clk", 32'(bus_if.cmd_ready), 0);
    @(negedge clk);
    #1;
    check_eq("cmd_ready_after_clk", 32'(bus_if.cmd_ready), 1);
  endtask

  initial begin
    int len;
    logic [1:0] op;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_op = '0; bus_if.cmd_xy = '0; bus_if.cmd_code = '0;
    bus_if.char_valid = 1'b0; bus_if.char_code_in = '0; bus_if.char_last = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // CLEAR with vblank held high
    vb_mode = 0; cv_mode = 0;
    push_cmd(OP_CLEAR, 8'h5A, 7'h11, 0);
    run_until_idle(400);

    // FILL 'A' with vblank 100 on / 100 off
    vb_mode = 1; tog_cnt = 0;
    push_cmd(OP_FILL, 8'h00, 7'h41, 0);
    run_until_idle(800);

    // WRITE "ABC" at 0x3E, then 2 beats at 0xFF wrapping to 0x00
    vb_mode = 0;
    pool.push_back(7'h41); pool.push_back(7'h42); pool.push_back(7'h43);
    push_cmd(OP_WRITE, 8'h3E, 7'h00, 3);
    pool.push_back(7'h5A); pool.push_back(7'h31);
    push_cmd(OP_WRITE, 8'hFF, 7'h00, 2);
    push_cmd(OP_NOP, 8'h12, 7'h34, 0);
    run_until_idle(100);

    // CLEAR presented while a WRITE is in progress
    cv_mode = 1;
    for (int i = 0; i < 6; i++) pool.push_back(7'($urandom));
    push_cmd(OP_WRITE, 8'h10, 7'h00, 6);
    push_cmd(OP_CLEAR, 8'h00, 7'h00, 0);
    run_until_idle(600);

    // Async reset mid-FILL, then CLEAR restarts from 0
    cv_mode = 0; vb_mode = 0; saw_80 = 0;
    push_cmd(OP_FILL, 8'h00, 7'h55, 0);
    for (int n = 0; n < 400 && !saw_80; n++) step();
    check_eq("reached_0x80", 32'(saw_80), 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pend.delete(); exp_q.delete();
    outstanding = 0; in_write = 0;
    bus_if.cmd_valid = 1'b0; bus_if.char_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_no_done", 32'(done), 0);
      check_eq("rst_no_wr", 32'(bus_if.wr_en), 0);
    end
    release_reset();
    push_cmd(OP_CLEAR, 8'h00, 7'h00, 0);
    run_until_idle(400);

    // Random command mix with random vblank and stream gaps
    vb_mode = 2; cv_mode = 1;
    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom);
      len = 0;
      if (op == OP_WRITE) begin
        len = 1 + int'($urandom % 20);
        for (int i = 0; i < len; i++) pool.push_back(7'($urandom));
      end
      push_cmd(op, 8'($urandom), 7'($urandom), len);
    end
    run_until_idle(30000);

    // Quiet tail: no stray writes or done pulses
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
